// File: rtl/onehot_sequencer.sv
// One-hot position sequencer: rotate up/down, bounce between the ends, and load,
// with self-recovery from any non-one-hot state and registered wrap/err pulses.
module onehot_sequencer #(
    parameter  int WIDTH = 4,
    localparam int PW    = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] next,
    output logic [PW-1:0]    pos,
    output logic             wrap,
    output logic             err
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] BIT0 = WIDTH'(1);

    logic [WIDTH-1:0] r_next;
    logic [PW-1:0]    r_pos;
    logic             r_dir_up;
    logic             r_wrap;
    logic             r_err;

    logic [WIDTH-1:0] w_next;
    logic             w_dir_up;
    logic             w_wrap;
    logic             w_err;
    logic             w_state_ok;
    logic             w_load_ok;

    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - BIT0)) == '0);
    endfunction

    // Only valid for one-hot input; every caller guarantees that.
    function automatic logic [PW-1:0] encode(input logic [WIDTH-1:0] v);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) idx = idx | PW'(i);
        end
        return idx;
    endfunction

    assign w_state_ok = is_onehot(r_next);
    assign w_load_ok  = is_onehot(load_val);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        w_next   = r_next;
        w_dir_up = r_dir_up;
        w_wrap   = 1'b0;
        w_err    = 1'b0;

        if (load) begin
            if (w_load_ok) begin
                w_next = load_val;
            end else begin
                w_next   = BIT0;
                w_dir_up = 1'b1;
                w_err    = 1'b1;
            end
        end else if (!w_state_ok) begin
            w_next   = BIT0;
            w_dir_up = 1'b1;
            w_err    = 1'b1;
        end else if (en) begin
            case (mode_e'(mode))
                MODE_UP: begin
                    w_next = {r_next[WIDTH-2:0], r_next[WIDTH-1]};
                    w_wrap = r_next[WIDTH-1];
                end
                MODE_DOWN: begin
                    w_next = {r_next[0], r_next[WIDTH-1:1]};
                    w_wrap = r_next[0];
                end
                MODE_BOUNCE: begin
                    if (r_dir_up && r_next[WIDTH-1]) begin
                        w_next   = r_next >> 1;
                        w_dir_up = 1'b0;
                        w_wrap   = 1'b1;
                    end else if (!r_dir_up && r_next[0]) begin
                        w_next   = r_next << 1;
                        w_dir_up = 1'b1;
                        w_wrap   = 1'b1;
                    end else begin
                        w_next = r_dir_up ? (r_next << 1) : (r_next >> 1);
                        // With two positions every bounce step lands on an end.
                        w_wrap = (WIDTH == 2);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_next   <= BIT0;
            r_pos    <= '0;
            r_dir_up <= 1'b1;
            r_wrap   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            r_next   <= w_next;
            r_pos    <= encode(w_next);
            r_dir_up <= w_dir_up;
            r_wrap   <= w_wrap;
            r_err    <= w_err;
        end
    end

    assign next = r_next;
    assign pos  = r_pos;
    assign wrap = r_wrap;
    assign err  = r_err;

endmodule

// File: tb/tb_onehot_sequencer.sv
// Bench for onehot_sequencer: index-based reference model compared every cycle,
// plus directed vectors with literal expectations (WIDTH=4 and WIDTH=2 instances).
module tb_onehot_sequencer;

    typedef struct {
        int pos;
        bit dir;
        bit bad;
        bit wrap;
        bit err;
    } mstate_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] next;
    logic [1:0] pos;
    logic       wrap;
    logic       err;

    logic [1:0] mode2;
    logic       en2;
    logic       load2;
    logic [1:0] load_val2;
    logic [1:0] next2;
    logic [0:0] pos2;
    logic       wrap2;
    logic       err2;

    int total = 0;
    int bad   = 0;

    mstate_t s1;
    mstate_t s2;

    onehot_sequencer #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .en(en), .load(load),
        .load_val(load_val), .next(next), .pos(pos), .wrap(wrap), .err(err)
    );

    onehot_sequencer #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .mode(mode2), .en(en2), .load(load2),
        .load_val(load_val2), .next(next2), .pos(pos2), .wrap(wrap2), .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect4(input string tag, input logic [3:0] n, input int p,
                           input bit w, input bit e);
        check({tag, ".next"}, 32'(next), 32'(n));
        check({tag, ".pos"},  32'(pos),  32'(p));
        check({tag, ".wrap"}, 32'(wrap), 32'(w));
        check({tag, ".err"},  32'(err),  32'(e));
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic mstate_t reset_state();
        mstate_t r;
        r.pos = 0; r.dir = 1'b1; r.bad = 1'b0; r.wrap = 1'b0; r.err = 1'b0;
        return r;
    endfunction

    // Positions are plain integers here; ends, turnarounds and wrap follow from index arithmetic.
    function automatic mstate_t model_step(mstate_t s, int w, bit ld, logic [31:0] lv,
                                           bit step_en, logic [1:0] md);
        mstate_t n;
        n = s;
        n.wrap = 1'b0;
        n.err  = 1'b0;
        if (ld) begin
            n.bad = 1'b0;
            if ($countones(lv) == 1) begin
                for (int i = 0; i < w; i++) if (lv[i]) n.pos = i;
            end else begin
                n.pos = 0; n.dir = 1'b1; n.err = 1'b1;
            end
        end else if (s.bad) begin
            n.pos = 0; n.dir = 1'b1; n.err = 1'b1; n.bad = 1'b0;
        end else if (step_en) begin
            case (md)
                2'b01: begin n.wrap = (s.pos == w - 1); n.pos = (s.pos + 1) % w; end
                2'b10: begin n.wrap = (s.pos == 0);     n.pos = (s.pos + w - 1) % w; end
                2'b11: begin
                    if (w == 2) begin
                        n.pos = 1 - s.pos; n.dir = (n.pos == 1); n.wrap = 1'b1;
                    end else if (s.dir && s.pos == w - 1) begin
                        n.pos = w - 2; n.dir = 1'b0; n.wrap = 1'b1;
                    end else if (!s.dir && s.pos == 0) begin
                        n.pos = 1; n.dir = 1'b1; n.wrap = 1'b1;
                    end else begin
                        n.pos = s.dir ? s.pos + 1 : s.pos - 1;
                    end
                end
                default: ;
            endcase
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 = reset_state();
            s2 = reset_state();
        end else begin
            s1 = model_step(s1, 4, load,  32'(load_val),  en,  mode);
            s2 = model_step(s2, 2, load2, 32'(load_val2), en2, mode2);
        end
    end

    always @(posedge clk) begin
        #2;
        check("cmp4.next", 32'(next), s1.bad ? 32'd0 : (32'd1 << s1.pos));
        if (!s1.bad) check("cmp4.pos", 32'(pos), 32'(s1.pos));
        check("cmp4.wrap", 32'(wrap), 32'(s1.wrap));
        check("cmp4.err",  32'(err),  32'(s1.err));
        check("cmp2.next", 32'(next2), 32'd1 << s2.pos);
        check("cmp2.pos",  32'(pos2),  32'(s2.pos));
        check("cmp2.wrap", 32'(wrap2), 32'(s2.wrap));
        check("cmp2.err",  32'(err2),  32'(s2.err));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] up_n [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        int         up_p [5] = '{1, 2, 3, 0, 1};
        bit         up_w [5] = '{0, 0, 0, 1, 0};
        logic [3:0] bn_n [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        int         bn_p [7] = '{1, 2, 3, 2, 1, 0, 1};
        bit         bn_w [7] = '{0, 0, 0, 1, 0, 0, 1};
        logic [1:0] w2_n [4] = '{2'b10, 2'b01, 2'b10, 2'b01};

        rst_n = 1'b0; mode = 2'b00; en = 1'b0; load = 1'b0; load_val = 4'b0000;
        mode2 = 2'b00; en2 = 1'b0; load2 = 1'b0; load_val2 = 2'b00;

        #12;
        expect4("reset", 4'b0001, 0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;

        mode = 2'b01; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            expect4($sformatf("rot_up%0d", i), up_n[i], up_p[i], up_w[i], 1'b0);
        end

        en = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mode = 2'b11; en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            expect4($sformatf("bounce%0d", i), bn_n[i], bn_p[i], bn_w[i], 1'b0);
        end

        load = 1'b1; load_val = 4'b0110; mode = 2'b01; en = 1'b1;
        step();
        expect4("load_multi", 4'b0001, 0, 1'b0, 1'b1);
        load_val = 4'b0100;
        step();
        expect4("load_ok", 4'b0100, 2, 1'b0, 1'b0);
        load = 1'b0;

        mode = 2'b00; en = 1'b1;
        step();
        expect4("hold_mode0", 4'b0100, 2, 1'b0, 1'b0);

        load = 1'b1; load_val = 4'b0000;
        step();
        expect4("load_zero", 4'b0001, 0, 1'b0, 1'b1);
        load_val = 4'b1000;
        step();
        expect4("load_msb", 4'b1000, 3, 1'b0, 1'b0);
        load = 1'b0;

        mode = 2'b10; en = 1'b1;
        step();
        expect4("down_en1", 4'b0100, 2, 1'b0, 1'b0);
        en = 1'b0;
        step();
        expect4("down_en0", 4'b0100, 2, 1'b0, 1'b0);
        en = 1'b1;
        step();
        expect4("down_en1b", 4'b0010, 1, 1'b0, 1'b0);
        step();
        expect4("down_lsb", 4'b0001, 0, 1'b0, 1'b0);
        step();
        expect4("down_wrap", 4'b1000, 3, 1'b1, 1'b0);
        en = 1'b0;

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst.next", 32'(next), 32'd1);
        check("async_rst.pos",  32'(pos),  32'd0);
        check("async_rst.wrap", 32'(wrap), 32'd0);
        step();
        rst_n = 1'b1;

        mode = 2'b11; en = 1'b1;
        for (int i = 0; i < 4; i++) step();
        expect4("bounce_turn", 4'b0100, 2, 1'b1, 1'b0);
        en = 1'b0; mode = 2'b00;
        force dut.r_next = 4'b0000;
        s1.bad = 1'b1;
        #1;
        release dut.r_next;
        check("upset_visible", 32'(next), 32'd0);
        mode = 2'b11; en = 1'b1;
        step();
        expect4("recover", 4'b0001, 0, 1'b0, 1'b1);
        step();
        expect4("recover_dir_up", 4'b0010, 1, 1'b0, 1'b0);
        en = 1'b0;

        mode2 = 2'b11; en2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("w2_bounce%0d.next", i), 32'(next2), 32'(w2_n[i]));
            check($sformatf("w2_bounce%0d.wrap", i), 32'(wrap2), 32'd1);
        end
        en2 = 1'b0;
        step();
        check("w2_idle.wrap", 32'(wrap2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
